// File: rtl/bank_wbuf_arbiter.sv
// ============================================================================
// Module      : bank_wbuf_arbiter
// Description : Arbitrates NUM_BANK bank requests onto one registered write-
//               buffer request channel, tracks grant order in an outstanding
//               FIFO and steers in-order return beats back to the requester.
//               Define WBUF_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_wbuf_arbiter #(
  parameter int NUM_BANK   = 4,
  parameter int OSTD_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_BANK-1:0]     bank_req_valid_i,
  output logic [NUM_BANK-1:0]     bank_req_ready_o,
  input  logic [2*NUM_BANK-1:0]   bank_req_channel_id_i,
  input  logic [8*NUM_BANK-1:0]   bank_req_wbuffer_id_i,
  output logic                    wbuf_req_valid_o,
  input  logic                    wbuf_req_ready_i,
  output logic [1:0]              wbuf_req_channel_id_o,
  output logic [7:0]              wbuf_req_wbuffer_id_o,
  input  logic                    wbuf_rtn_valid_i,
  output logic                    wbuf_rtn_ready_o,
  input  logic [127:0]            wbuf_rtn_data_i,
  output logic [NUM_BANK-1:0]     bank_rtn_valid_o,
  input  logic [NUM_BANK-1:0]     bank_rtn_ready_i,
  output logic [127:0]            bank_rtn_data_o
);

  localparam int BW = $clog2(NUM_BANK);
  localparam int PW = $clog2(OSTD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(OSTD_DEPTH);

  logic          hold_valid_q, hold_valid_d;
  logic [1:0]    hold_ch_q, hold_ch_d;
  logic [7:0]    hold_id_q, hold_id_d;
  logic [BW-1:0] fifo_q [OSTD_DEPTH];
  logic [BW-1:0] fifo_d [OSTD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ostd_cnt_q, ostd_cnt_d;

  logic          grant_found;
  logic [BW-1:0] grant_idx;
  logic          req_fire, can_accept, push, pop, ne;
  logic [BW-1:0] head;

`ifdef WBUF_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_BANK - 1; i >= 0; i--) begin
      if (bank_req_valid_i[i]) begin
        grant_found = 1'b1;
        grant_idx   = BW'(i);
      end
    end
  end
`else
  logic [BW-1:0] rr_ptr_q, rr_ptr_d;

  // Scan downward so the smallest offset from rr_ptr is the last one to win.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_BANK - 1; i >= 0; i--) begin
      cand = (int'(rr_ptr_q) + i) % NUM_BANK;
      if (bank_req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = BW'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (grant_idx == BW'(NUM_BANK - 1)) ? '0 : grant_idx + BW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign req_fire   = hold_valid_q & wbuf_req_ready_i;
  // A pop in the same cycle does not free a slot for a push.
  assign can_accept = (~hold_valid_q | req_fire) & (ostd_cnt_q != C_FULL);
  assign push       = can_accept & grant_found;
  assign bank_req_ready_o = push ? ({{(NUM_BANK-1){1'b0}}, 1'b1} << grant_idx) : '0;

  assign ne               = (ostd_cnt_q != '0);
  assign head             = fifo_q[rd_ptr_q];
  assign wbuf_rtn_ready_o = ne & bank_rtn_ready_i[head];
  assign pop              = wbuf_rtn_valid_i & wbuf_rtn_ready_o;
  assign bank_rtn_data_o  = wbuf_rtn_data_i;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_rtn_valid
    assign bank_rtn_valid_o[b] = wbuf_rtn_valid_i & ne & (head == BW'(b));
  end

  assign wbuf_req_valid_o      = hold_valid_q;
  assign wbuf_req_channel_id_o = hold_ch_q;
  assign wbuf_req_wbuffer_id_o = hold_id_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_ch_d    = hold_ch_q;
    hold_id_d    = hold_id_q;
    if (push) begin
      hold_valid_d = 1'b1;
      hold_ch_d    = bank_req_channel_id_i[{grant_idx, 1'b0} +: 2];
      hold_id_d    = bank_req_wbuffer_id_i[{grant_idx, 3'b000} +: 8];
    end else if (req_fire) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ostd_cnt_d = ostd_cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = grant_idx;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   ostd_cnt_d = ostd_cnt_q + CW'(1);
      2'b01:   ostd_cnt_d = ostd_cnt_q - CW'(1);
      default: ostd_cnt_d = ostd_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_ch_q    <= '0;
      hold_id_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ostd_cnt_q   <= '0;
      for (int i = 0; i < OSTD_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_ch_q    <= hold_ch_d;
      hold_id_q    <= hold_id_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ostd_cnt_q   <= ostd_cnt_d;
      fifo_q       <= fifo_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bank_wbuf_arbiter.sv
// ============================================================================
// Module      : tb_bank_wbuf_arbiter
// Description : Directed scoreboard bench for bank_wbuf_arbiter (4 banks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_wbuf_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   bank_req_valid_i;
  logic [3:0]   bank_req_ready_o;
  logic [7:0]   bank_req_channel_id_i;
  logic [31:0]  bank_req_wbuffer_id_i;
  logic         wbuf_req_valid_o;
  logic         wbuf_req_ready_i;
  logic [1:0]   wbuf_req_channel_id_o;
  logic [7:0]   wbuf_req_wbuffer_id_o;
  logic         wbuf_rtn_valid_i;
  logic         wbuf_rtn_ready_o;
  logic [127:0] wbuf_rtn_data_i;
  logic [3:0]   bank_rtn_valid_o;
  logic [3:0]   bank_rtn_ready_i;
  logic [127:0] bank_rtn_data_o;

  int errors = 0;
  int checks = 0;

  logic [9:0]   req_q[$];
  logic [3:0]   rtn_bank_q[$];
  logic [127:0] rtn_data_q[$];

  bank_wbuf_arbiter #(.NUM_BANK(4), .OSTD_DEPTH(4)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .bank_req_valid_i      (bank_req_valid_i),
    .bank_req_ready_o      (bank_req_ready_o),
    .bank_req_channel_id_i (bank_req_channel_id_i),
    .bank_req_wbuffer_id_i (bank_req_wbuffer_id_i),
    .wbuf_req_valid_o      (wbuf_req_valid_o),
    .wbuf_req_ready_i      (wbuf_req_ready_i),
    .wbuf_req_channel_id_o (wbuf_req_channel_id_o),
    .wbuf_req_wbuffer_id_o (wbuf_req_wbuffer_id_o),
    .wbuf_rtn_valid_i      (wbuf_rtn_valid_i),
    .wbuf_rtn_ready_o      (wbuf_rtn_ready_o),
    .wbuf_rtn_data_i       (wbuf_rtn_data_i),
    .bank_rtn_valid_o      (bank_rtn_valid_o),
    .bank_rtn_ready_i      (bank_rtn_ready_i),
    .bank_rtn_data_o       (bank_rtn_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_bank(input int b, input logic [1:0] ch, input logic [7:0] id);
    bank_req_channel_id_i[2*b +: 2] = ch;
    bank_req_wbuffer_id_i[8*b +: 8] = id;
  endtask

  task automatic do_reset();
    rst_i            = 1'b1;
    bank_req_valid_i = '0;
    wbuf_req_ready_i = 1'b1;
    wbuf_rtn_valid_i = 1'b0;
    wbuf_rtn_data_i  = '0;
    bank_rtn_ready_i = 4'hF;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Scoreboard monitors: pop an expectation at every handshake.
  always @(negedge clk_i) begin
    if (!rst_i && wbuf_req_valid_o && wbuf_req_ready_i) begin
      if (req_q.size() == 0) check("req_unexpected", 1, 0);
      else check("req_ch_id", {wbuf_req_channel_id_o, wbuf_req_wbuffer_id_o}, req_q.pop_front());
    end
    if (!rst_i && wbuf_rtn_valid_i && wbuf_rtn_ready_o) begin
      if (rtn_bank_q.size() == 0) check("rtn_unexpected", 1, 0);
      else begin
        check("rtn_bank", bank_rtn_valid_o, rtn_bank_q.pop_front());
        check("rtn_data", bank_rtn_data_o, rtn_data_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bank_req_channel_id_i = '0;
    bank_req_wbuffer_id_i = '0;
    do_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_req_valid", wbuf_req_valid_o, 0);
    check("rst_req_ch", wbuf_req_channel_id_o, 0);
    check("rst_req_id", wbuf_req_wbuffer_id_o, 0);
    check("rst_bank_ready", bank_req_ready_o, 0);
    check("rst_rtn_valid", bank_rtn_valid_o, 0);
    check("rst_rtn_ready", wbuf_rtn_ready_o, 0);
    tick();
    rst_i = 1'b0;

    // Single request from bank 2
    do_reset();
    set_bank(2, 2'd1, 8'h35);
    req_q.push_back({2'd1, 8'h35});
    bank_req_valid_i = 4'b0100;
    @(negedge clk_i);
    check("single_grant", bank_req_ready_o, 4'b0100);
    tick();
    bank_req_valid_i = '0;
    @(negedge clk_i);
    check("single_latency", wbuf_req_valid_o, 1);
    tick();
    rtn_bank_q.push_back(4'b0100);
    rtn_data_q.push_back({16{8'hAA}});
    wbuf_rtn_valid_i = 1'b1;
    wbuf_rtn_data_i  = {16{8'hAA}};
    tick();
    wbuf_rtn_valid_i = 1'b0;

    // Fairness with all banks requesting and immediate returns
    do_reset();
    for (int b = 0; b < 4; b++) set_bank(b, 2'(b), 8'h40 + 8'(b));
    begin
`ifdef WBUF_ARB_FIXED_PRIO_EN
      int order[6] = '{0, 0, 0, 0, 0, 0};
`else
      int order[6] = '{0, 1, 2, 3, 0, 1};
`endif
      for (int k = 0; k < 6; k++) begin
        req_q.push_back({2'(order[k]), 8'h40 + 8'(order[k])});
        rtn_bank_q.push_back(4'b0001 << order[k]);
        rtn_data_q.push_back({8{16'hF00D}});
      end
    end
    wbuf_rtn_data_i  = {8{16'hF00D}};
    wbuf_rtn_valid_i = 1'b1;
    bank_req_valid_i = 4'hF;
    for (int k = 0; k < 6; k++) tick();
    bank_req_valid_i = '0;
    tick();
    wbuf_rtn_valid_i = 1'b0;
    tick();
    check("fair_req_drained", req_q.size(), 0);
    check("fair_rtn_drained", rtn_bank_q.size(), 0);

    // Backpressure with banks 1 and 3
    do_reset();
    set_bank(1, 2'd1, 8'h11);
    set_bank(3, 2'd3, 8'h33);
    req_q.push_back({2'd1, 8'h11});
    req_q.push_back({2'd3, 8'h33});
    wbuf_req_ready_i = 1'b0;
    bank_req_valid_i = 4'b1010;
    tick();
    bank_req_valid_i = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("bp_hold_id", {wbuf_req_valid_o, wbuf_req_wbuffer_id_o}, {1'b1, 8'h11});
      check("bp_no_grant", bank_req_ready_o, 0);
      tick();
    end
    wbuf_req_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_same_cycle_grant", bank_req_ready_o, 4'b1000);
    tick();
    bank_req_valid_i = '0;
    tick();
    check("bp_req_drained", req_q.size(), 0);

    // Outstanding limit
    do_reset();
    set_bank(0, 2'd0, 8'h50);
    for (int k = 0; k < 5; k++) req_q.push_back({2'd0, 8'h50});
    rtn_bank_q.push_back(4'b0001);
    rtn_data_q.push_back({4{32'h1234_5678}});
    wbuf_rtn_data_i  = {4{32'h1234_5678}};
    bank_req_valid_i = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk_i);
    check("ostd_full_block", bank_req_ready_o, 0);
    tick();
    wbuf_rtn_valid_i = 1'b1;
    @(negedge clk_i);
    check("ostd_full_pop_block", bank_req_ready_o, 0);
    tick();
    wbuf_rtn_valid_i = 1'b0;
    @(negedge clk_i);
    check("ostd_regrant", bank_req_ready_o, 4'b0001);
    tick();
    bank_req_valid_i = '0;
    tick();
    check("ostd_req_drained", req_q.size(), 0);

    // Return routing and stall: bank 3 then bank 0
    do_reset();
    set_bank(3, 2'd2, 8'h63);
    set_bank(0, 2'd1, 8'h60);
    req_q.push_back({2'd2, 8'h63});
    req_q.push_back({2'd1, 8'h60});
    bank_req_valid_i = 4'b1000;
    tick();
    bank_req_valid_i = 4'b0001;
    tick();
    bank_req_valid_i = '0;
    bank_rtn_ready_i = 4'b0111;
    wbuf_rtn_valid_i = 1'b1;
    wbuf_rtn_data_i  = {4{32'hD1D1_D1D1}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("stall_ready", wbuf_rtn_ready_o, 0);
      check("stall_valid", bank_rtn_valid_o, 4'b1000);
      tick();
    end
    rtn_bank_q.push_back(4'b1000);
    rtn_data_q.push_back({4{32'hD1D1_D1D1}});
    rtn_bank_q.push_back(4'b0001);
    rtn_data_q.push_back({4{32'hD2D2_D2D2}});
    bank_rtn_ready_i = 4'hF;
    tick();
    wbuf_rtn_data_i = {4{32'hD2D2_D2D2}};
    tick();
    wbuf_rtn_valid_i = 1'b0;
    tick();
    check("route_rtn_drained", rtn_bank_q.size(), 0);

    // Reset mid-operation
    do_reset();
    set_bank(0, 2'd0, 8'h70);
    set_bank(1, 2'd1, 8'h71);
    req_q.push_back({2'd0, 8'h70});
    req_q.push_back({2'd0, 8'h70});
    bank_req_valid_i = 4'b0001;
    for (int k = 0; k < 3; k++) tick();
    bank_req_valid_i = '0;
    wbuf_req_ready_i = 1'b0;
    @(negedge clk_i);
    check("mid_hold_valid", wbuf_req_valid_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_async_clear", wbuf_req_valid_o, 0);
    tick();
    rst_i = 1'b0;
    wbuf_rtn_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      check("mid_rtn_stalled", wbuf_rtn_ready_o, 0);
      check("mid_rtn_no_valid", bank_rtn_valid_o, 0);
      check("mid_req_valid", wbuf_req_valid_o, 0);
      tick();
    end
    wbuf_rtn_valid_i = 1'b0;
    bank_req_valid_i = 4'b0011;
    @(negedge clk_i);
    check("mid_rr_reset", bank_req_ready_o, 4'b0001);
    tick();
    bank_req_valid_i = '0;
    tick();
    check("final_req_drained", req_q.size(), 0);
    check("final_rtn_drained", rtn_bank_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bank_wbuf_arbiter.md
# bank_wbuf_arbiter

Shares one write-buffer read port among `NUM_BANK` bank SRAM controllers. It arbitrates the banks' `rc_wbuf_req` requests onto a single registered request channel to the write buffer. It records the grant order in an outstanding-order FIFO and routes each in-order `rtn` data beat back to the bank that issued the matching request. It sits between the per-bank `bank_sram_controller` instances and the write buffer.

## Interface
Parameters:
- `NUM_BANK`, 4: number of requesting banks (2..8).
- `OSTD_DEPTH`, 4: maximum outstanding requests; power of 2, at least 2.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `bank_req_valid_i` in NUM_BANK: per-bank request valid.
- `bank_req_ready_o` out NUM_BANK: per-bank request accept.
- `bank_req_channel_id_i` in 2*NUM_BANK: channel id, bank b at [2b+1:2b].
- `bank_req_wbuffer_id_i` in 8*NUM_BANK: write-buffer entry, bank b at [8b+7:8b].
- `wbuf_req_valid_o` out 1: request to write buffer.
- `wbuf_req_ready_i` in 1: write buffer accepts request.
- `wbuf_req_channel_id_o` out 2: forwarded channel id.
- `wbuf_req_wbuffer_id_o` out 8: forwarded entry id.
- `wbuf_rtn_valid_i` in 1: return data valid; returns are in request order.
- `wbuf_rtn_ready_o` out 1: return accepted.
- `wbuf_rtn_data_i` in 128: return data.
- `bank_rtn_valid_o` out NUM_BANK: per-bank return valid; at most one bit set.
- `bank_rtn_ready_i` in NUM_BANK: per-bank return ready.
- `bank_rtn_data_o` out 128: return data, broadcast to all banks, equal to `wbuf_rtn_data_i`.

## Operation
State:
- Request holding register: valid, channel, wbuffer id.
- Round-robin pointer `rr_ptr`, width clog2(NUM_BANK).
- Order FIFO of bank indices, depth OSTD_DEPTH, with count `ostd_cnt` of width clog2(OSTD_DEPTH)+1.

Request side:
- `can_accept` = (holding register empty, or `wbuf_req_valid_o & wbuf_req_ready_i`) & (`ostd_cnt` != OSTD_DEPTH).
- Full blocks a push even if a pop happens in the same cycle.
- Grant: the first bank with valid set, searching from `rr_ptr` upward and wrapping modulo NUM_BANK.
- `bank_req_ready_o` is one-hot on the granted bank when `can_accept`, otherwise all zero.
- On a grant to bank g:
  - The holding register loads g's channel and wbuffer id with valid=1.
  - g is pushed into the order FIFO.
  - `rr_ptr` <= g+1, wrapping from NUM_BANK-1 to 0.
- With no grant, `rr_ptr` holds.
- The holding register clears on `wbuf_req_valid_o & wbuf_req_ready_i` with no new grant.
- Outputs are stable while valid and not ready.

Return side, with head = FIFO head bank index and `ne` = FIFO not empty:
- `bank_rtn_valid_o[head]` = `wbuf_rtn_valid_i & ne`; all other bits 0.
- `wbuf_rtn_ready_o` = `ne & bank_rtn_ready_i[head]`.
- Pop on `wbuf_rtn_valid_i & wbuf_rtn_ready_o`.
- A return while the FIFO is empty is not accepted: ready stays 0 and the beat stalls.

Count update:
- `ostd_cnt` +1 on push only, -1 on pop only, unchanged on push and pop together.
- It never exceeds OSTD_DEPTH.
- FIFO read and write pointers wrap modulo OSTD_DEPTH.

## Timing
- Reset values: `wbuf_req_valid_o`=0, `wbuf_req_channel_id_o`=0, `wbuf_req_wbuffer_id_o`=0, `rr_ptr`=0, FIFO empty with `ostd_cnt`=0.
- After reset, `bank_req_ready_o`, `bank_rtn_valid_o` and `wbuf_rtn_ready_o` are all 0 until driven by the rules above.
- Request latency: a bank handshake in cycle N gives `wbuf_req_valid_o`=1 in N+1.
- Throughput is one request per cycle under continuous `wbuf_req_ready_i`.
- Return path is combinational, 0 cycles; data is never registered.
- A request pushed in cycle N can be returned from cycle N+1 onward.
- Reset asserted mid-operation discards the holding register and all outstanding entries immediately. Returns pending at the write buffer across reset are the environment's responsibility.

## Configuration
- `WBUF_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest bank index wins, and `rr_ptr` is not implemented.
- Not defined: round-robin as described in Operation.
- Handshake, FIFO and timing behaviour are identical in both builds.

## Test plan
- Single request: bank 2 requests ch=1, id=0x35 with `wbuf_req_ready_i`=1 → `wbuf_req_*` shows 1/0x35 one cycle later. A return of 0xAA.. then raises only `bank_rtn_valid_o[2]`, with data 0xAA...
- Fairness: all 4 banks request continuously, ready=1, returns immediate → grant order 0,1,2,3,0,1. With `WBUF_ARB_FIXED_PRIO_EN` defined → bank 0 every cycle.
- Backpressure: `wbuf_req_ready_i`=0 for 5 cycles with bank 1 and bank 3 requesting → outputs hold bank 1's id and `bank_req_ready_o`=0. When ready rises, bank 3 is granted the same cycle.
- Outstanding limit: 4 requests accepted with no returns → `bank_req_ready_o`=0 while `ostd_cnt`=4. Popping one return re-enables a grant in the next cycle.
- Return routing and stall: order bank 3 then bank 0 with `bank_rtn_ready_i[3]`=0 → `wbuf_rtn_ready_o`=0 and no pop. After release, bank 3 receives the first beat and bank 0 the second.
- Reset mid-operation: 3 outstanding plus a valid holding register, then `rst_i` pulse → `wbuf_req_valid_o`=0, FIFO empty, `rr_ptr`=0, and a following return is stalled with `wbuf_rtn_ready_o`=0.
